// File: rtl/fir_serial_mac_pkg.sv
// Shared widths, FSM encoding and output rounding/saturation for the serial-MAC FIR family.
package fir_serial_mac_pkg;

   localparam int SAMPLE_W = 12;
   localparam int COEF_W   = 12;
   localparam int PROD_W   = 24;
   localparam int ACC_W    = 27;
   localparam int OUT_W    = 22;
   localparam int NTAPS    = 5;
   localparam int SHIFT    = 3;

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 <<< (OUT_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 <<< (OUT_W-1)));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // 27-bit Q.21 accumulator to 22-bit Q.18: drop SHIFT bits, round half up, clamp.
   function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] sh;
      logic signed [ACC_W-1:0] rb;
      logic signed [ACC_W-1:0] r;
      sh    = a >>> SHIFT;
      rb    = '0;
      rb[0] = a[SHIFT-1];
      r     = sh + rb;
      if (r > SAT_HI)
         return SAT_HI[OUT_W-1:0];
      else if (r < SAT_LO)
         return SAT_LO[OUT_W-1:0];
      else
         return r[OUT_W-1:0];
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from the wide accumulator to the output format.
module fir_round_sat
   import fir_serial_mac_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] res
);

   assign res = round_sat($signed(acc));

endmodule

// File: rtl/fir_serial_mac.sv
// Five-tap FIR with one shared multiplier stepping through the taps; one result per accepted sample.
// Ready/valid on both sides; the coefficient bank and delay line live here.
module fir_serial_mac
   import fir_serial_mac_pkg::*;
#(
   parameter logic [COEF_W-1:0] COEF0 = 12'h400,
   parameter logic [COEF_W-1:0] COEF1 = 12'h000,
   parameter logic [COEF_W-1:0] COEF2 = 12'h000,
   parameter logic [COEF_W-1:0] COEF3 = 12'h000,
   parameter logic [COEF_W-1:0] COEF4 = 12'h000
)
(
   input  logic                clk,
   input  logic                rstn,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [OUT_W-1:0]    out_data,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                coef_we,
   input  logic [2:0]          coef_addr,
   input  logic [COEF_W-1:0]   coef_data,
   output logic                coef_err
);

   state_t                      state;
   logic [2:0]                  idx;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     acc_next;
   logic signed [SAMPLE_W-1:0]  dly  [NTAPS];
   logic signed [COEF_W-1:0]    coef [NTAPS];
   logic signed [SAMPLE_W-1:0]  d_sel;
   logic signed [COEF_W-1:0]    c_sel;
   logic signed [PROD_W-1:0]    prod;
   logic [OUT_W-1:0]            rs;
   logic                        wr_ok;

   // Writes only land while idle, so a running sum never mixes old and new taps.
   assign wr_ok = coef_we && (state == IDLE) && (coef_addr <= 3'd4);

   always_comb begin
      d_sel = '0;
      c_sel = '0;
      for (int k = 0; k < NTAPS; k++) begin
         if (idx == 3'(k)) begin
            d_sel = dly[k];
            c_sel = coef[k];
         end
      end
   end

   assign prod     = d_sel * c_sel;
   assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   // The last product is folded in before rounding, so the result is ready on the idx=4 edge.
   fir_round_sat u_round_sat (
      .acc (acc_next),
      .res (rs)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         coef_err  <= 1'b0;
         for (int k = 0; k < NTAPS; k++)
            dly[k] <= '0;
         coef[0] <= COEF0;
         coef[1] <= COEF1;
         coef[2] <= COEF2;
         coef[3] <= COEF3;
         coef[4] <= COEF4;
      end else begin
         coef_err <= coef_we && !wr_ok;
         if (wr_ok) begin
            for (int k = 0; k < NTAPS; k++)
               if (coef_addr == 3'(k))
                  coef[k] <= coef_data;
         end

         case (state)
            IDLE: begin
               if (in_valid) begin
                  dly[0] <= in_data;
                  for (int k = 1; k < NTAPS; k++)
                     dly[k] <= dly[k-1];
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= acc_next;
               idx <= idx + 3'd1;
               if (idx == 3'(NTAPS-1)) begin
                  out_data  <= rs;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac against an arithmetic reference of the filter equation.
module tb_fir_serial_mac;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [11:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [21:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        coef_we = 1'b0;
   logic [2:0]  coef_addr = '0;
   logic [11:0] coef_data = '0;
   logic        coef_err;

   int errors = 0;
   int checks = 0;
   int bp_mode = 0;

   logic [21:0] exp_q[$];
   logic [21:0] got[$];
   int coef_m[5];
   int hist_m[5];

   fir_serial_mac dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .coef_err  (coef_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      coef_m = '{1024, 0, 0, 0, 0};
      hist_m = '{0, 0, 0, 0, 0};
   endtask

   // y = sum c[k]*x[n-k] in Q.21, then round half up to Q.18 and clamp to 22 bits.
   function automatic logic [21:0] model_accept(input int x);
      int s;
      int r;
      for (int k = 4; k > 0; k--) hist_m[k] = hist_m[k-1];
      hist_m[0] = x;
      s = 0;
      for (int k = 0; k < 5; k++) s += coef_m[k] * hist_m[k];
      r = (s + 4) >>> 3;
      if (r > 2097151) r = 2097151;
      if (r < -2097152) r = -2097152;
      return r[21:0];
   endfunction

   always @(posedge clk) begin
      #2;
      if (bp_mode == 0)      out_ready = 1'b1;
      else if (bp_mode == 1) out_ready = 1'b0;
      else                   out_ready = ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         got.push_back(out_data);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%0h, expected no output", out_data);
         end else begin
            chk("out_data", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) chk("idle_timeout", 0, 1);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [11:0] x);
      int n = 0;
      int xi;
      in_data  = x;
      in_valid = 1'b1;
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      xi = $signed(x);
      exp_q.push_back(model_accept(xi));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wcoef(input logic [2:0] a, input logic [11:0] d, input logic exp_err);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      @(negedge clk);
      coef_we = 1'b0;
      chk("coef_err_pulse", int'(coef_err), int'(exp_err));
      if (!exp_err) coef_m[a] = $signed(d);
      @(negedge clk);
      chk("coef_err_clear", int'(coef_err), 0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
      chk("drain_left", exp_q.size(), 0);
      wait_idle();
   endtask

   task automatic chk_got(input string nm, input int i, input logic [21:0] want);
      if (got.size() > i) chk(nm, int'(got[i]), int'(want));
      else chk({nm, "_missing"}, got.size(), i + 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      logic [21:0] hold;
      model_reset();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_coef_err", int'(coef_err), 0);
      chk("rst_out_data", int'(out_data), 0);

      // Default taps, unit sample then zeros; also first-result latency.
      got.delete();
      send(12'h400);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("latency", n, 5);
      for (int i = 0; i < 4; i++) send(12'h000);
      drain();
      chk_got("dflt0", 0, 22'h20000);
      for (int i = 1; i < 5; i++) chk_got("dflt_tail", i, 22'h0);

      // Impulse response with taps 1..5 LSB.
      for (int k = 0; k < 5; k++) wcoef(3'(k), 12'(k + 1), 1'b0);
      got.delete();
      send(12'd1024);
      for (int i = 0; i < 4; i++) send(12'h000);
      drain();
      for (int i = 0; i < 5; i++) chk_got("impulse", i, 22'(128 * (i + 1)));

      // Positive then negative saturation.
      for (int k = 0; k < 5; k++) wcoef(3'(k), 12'h800, 1'b0);
      got.delete();
      for (int i = 0; i < 5; i++) send(12'h800);
      drain();
      chk_got("sat_pos", 4, 22'h1FFFFF);
      for (int k = 0; k < 5; k++) wcoef(3'(k), 12'h7FF, 1'b0);
      got.delete();
      for (int i = 0; i < 5; i++) send(12'h800);
      drain();
      chk_got("sat_neg", 4, 22'h200000);

      // Rounding at the half-LSB boundary on both signs.
      wcoef(3'd0, 12'd1, 1'b0);
      for (int k = 1; k < 5; k++) wcoef(3'(k), 12'd0, 1'b0);
      got.delete();
      send(12'd4);
      send(12'd3);
      send(12'hFFC);
      send(12'hFFB);
      drain();
      chk_got("round_p4", 0, 22'd1);
      chk_got("round_p3", 1, 22'd0);
      chk_got("round_m4", 2, 22'd0);
      chk_got("round_m5", 3, 22'h3FFFFF);

      // Backpressure: result held stable, input blocked, resumes after release.
      wcoef(3'd1, 12'h123, 1'b0);
      bp_mode = 1;
      send(12'h2A5);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      hold = out_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_hold", int'(out_data), int'(hold));
         chk("bp_in_ready", int'(in_ready), 0);
      end
      bp_mode = 0;
      n = 0;
      while (out_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_resume_ready", int'(in_ready), 1);
      send(12'h155);
      drain();

      // Rejected coefficient writes: during MAC, then out-of-range address.
      send(12'h0F0);
      wcoef(3'd0, 12'h321, 1'b1);
      drain();
      wcoef(3'd6, 12'h055, 1'b1);
      send(12'h00F);
      drain();

      // Reset mid-MAC aborts the sample and restores defaults.
      send(12'h3C3);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      model_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_valid", int'(out_valid), 0);
      end
      chk("abort_idle", int'(in_ready), 1);

      // Randomized traffic with random backpressure and idle-time tap writes.
      bp_mode = 2;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            wcoef(3'($urandom_range(0, 4)), 12'($urandom), 1'b0);
         end
         send(12'($urandom));
      end
      drain();
      bp_mode = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

Five-tap FIR filter that computes one output per input sample with a single shared 12x12 multiplier, iterating over the taps sequentially. It is the folded, handshake-driven form of the team's parallel direct-form filter. It uses the same number formats: 12.10 samples, 12.11 coefficients, 22.18 results. Coefficients are runtime-programmable. It sits between the sample source and the downstream consumer in the filter datapath, and a ready/valid handshake on both sides provides backpressure.

## Interface
- COEF0, 12'sh400, reset value of tap 0 (0.5 in 12.11)
- COEF1..COEF4, 12'sh000, reset values of taps 1..4
- clk  in  1  clock
- rstn  in  1  reset rstn, synchronous, active-low; clock clk
- in_data  in  12  signed sample, 12.10
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- out_data  out  22  signed result, 22.18
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  3  tap index 0..4
- coef_data  in  12  signed coefficient, 12.11
- coef_err  out  1  one-cycle pulse: write rejected

## Operation
- Computes y[n] = sum over k=0..4 of c[k]*x[n-k]. x[n] is the newest sample.
- Delay line: five 12-bit signed registers d0..d4, reset 0. On sample accept: d0<=in_data, dk<=d(k-1).
- FSM has three states:
  - IDLE: in_ready=1. On in_valid, shift the delay line, clear the accumulator, set idx=0, go to MAC.
  - MAC: each cycle does acc += d[idx]*c[idx] and increments idx. On the idx=4 cycle, register the final result into out_data and go to OUT.
  - OUT: out_valid=1, out_data held stable. On out_ready, go to IDLE.
- Arithmetic:
  - Product is 24-bit signed, 21 fractional bits.
  - Accumulator is 27-bit signed. It cannot overflow.
  - Final value: take the 27-bit sum including the last product. Arithmetic-shift right by 3 and add bit 2 (round half up). Saturate to 22 bits, range -2^21..2^21-1.
- Coefficient writes:
  - Accepted only in IDLE with coef_addr<=4. They take effect for the next accepted sample.
  - A write in MAC/OUT, or with coef_addr>=5, is dropped and pulses coef_err for one cycle.
  - A write and a sample accept on the same IDLE cycle: the write applies and is used by that sample.
- Reset:
  - Coefficients reset to COEF0..COEF4.
  - Delay line, acc, idx and out_data reset to 0. FSM resets to IDLE.
  - in_ready=1 from the first cycle after reset; out_valid=0; coef_err=0.
  - Reset asserted mid-MAC or mid-OUT aborts the computation. No output is produced for that sample, and the sample stays lost from the delay line (cleared).

## Timing
- Latency: a sample accepted at edge E0 gives out_valid=1 after edge E5, i.e. 5 cycles later.
- Throughput with out_ready tied high: one sample per 7 cycles (accept, 5 MAC, 1 OUT).
- in_ready is 0 throughout MAC and OUT. in_valid is ignored there and the upstream source must hold its data.
- out_valid stays high and out_data stays stable until out_ready is sampled high. in_ready rises the cycle after the out handshake.
- coef_err is registered and asserts the cycle after the offending coef_we.

## Structure
- Shared package holds:
  - width constants: SAMPLE_W=12, COEF_W=12, PROD_W=24, ACC_W=27, OUT_W=22, NTAPS=5, SHIFT=3
  - FSM state encoding (IDLE, MAC, OUT)
  - a round/saturate function
- One natural sub-module: fir_round_sat. It is combinational, 27-bit in and 22-bit out, and is shared with future filter variants.
- The coefficient bank and delay line stay in the top module.

## Test plan
- Reset default, out_ready=1, in_data=12'sh400 (1.0) then zeros → outputs 0x20000, 0, 0, 0, 0. The first out_valid comes 5 cycles after accept.
- Impulse response: write c0..c4 = 1, 2, 3, 4, 5 LSB; input 1024 then zeros → outputs 128, 256, 384, 512, 640.
- Saturation: all coefficients 12'sh800 (-1.0), five samples of 12'sh800 (-2.0) → fifth output saturates to 0x1FFFFF. Negative saturation with coefficients 12'sh7FF → 0x200000.
- Rounding: c0=1, others 0. Input 4 → out 1; input 3 → out 0; input -4 → out 0; input -5 → out -1.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_data stable, in_ready=0. Release → accept resumes the next cycle with no sample lost.
- Coefficient write in MAC, then write to addr 6 → coef_err pulses once for each and coefficients stay unchanged. Assert reset during MAC → out_valid never rises and state is back in IDLE.
